whirlpool_wcipher_mu_serializer: RTL



---
 rtl/whirlpool_wcipher_mu_serializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/whirlpool_wcipher_mu_serializer.sv
// Whirlpool W-Cipher forward Mu, streaming form: accepts one 512-bit state
// vector A and emits the 8x8 byte matrix B one row per cycle.
// Optional feature macro: WHIRLPOOL_MU_PREFETCH_EN (adds a one-block holding
// buffer so back-to-back blocks stream with no bubble).
module whirlpool_wcipher_mu_serializer #(
    parameter bit OUT_ZERO_WHEN_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:511] A,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_row,
    output logic         out_last,
    output logic [7:0]   R0,
    output logic [7:0]   R1,
    output logic [7:0]   R2,
    output logic [7:0]   R3,
    output logic [7:0]   R4,
    output logic [7:0]   R5,
    output logic [7:0]   R6,
    output logic [7:0]   R7
);

    localparam int unsigned BLK_W = 512;
    localparam int unsigned ROW_W = 64;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   row_q, row_d;

    logic               in_xfer;
    logic               out_xfer;
    logic               last_xfer;
    logic [ROW_W-1:0]   row_sel;
    logic [ROW_W-1:0]   row_out;

`ifdef WHIRLPOOL_MU_PREFETCH_EN
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
`endif

    // Handshake decode from registered state
`ifdef WHIRLPOOL_MU_PREFETCH_EN
    assign in_ready  = !buf_full_q;
`else
    assign in_ready  = (state_q == ST_IDLE);
`endif
    assign out_valid = (state_q == ST_EMIT);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign last_xfer = out_xfer & (row_q == IDX_W'(7));

    // Row presentation: A[0] lands in shreg_q[511], so the top 64 bits are row 0 with B00 in R0
    assign row_sel  = shreg_q[BLK_W-1 -: ROW_W];
    assign row_out  = (OUT_ZERO_WHEN_IDLE && !out_valid) ? {ROW_W{1'b0}} : row_sel;
    assign R0       = row_out[63:56];
    assign R1       = row_out[55:48];
    assign R2       = row_out[47:40];
    assign R3       = row_out[39:32];
    assign R4       = row_out[31:24];
    assign R5       = row_out[23:16];
    assign R6       = row_out[15:8];
    assign R7       = row_out[7:0];
    assign out_row  = row_q;
    assign out_last = out_valid & (row_q == IDX_W'(7));

    // Next-state logic: load on accept, shift one row per output transfer
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        row_d   = row_q;
`ifdef WHIRLPOOL_MU_PREFETCH_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    shreg_d = A;
                    row_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_xfer) begin
                    // 3-bit counter wraps 7 -> 0 on the final row
                    row_d = row_q + IDX_W'(1);
                    if (last_xfer) begin
                        // Final row is left in place so the outputs can hold it when idle
`ifdef WHIRLPOOL_MU_PREFETCH_EN
                        if (buf_full_q) begin
                            shreg_d    = buf_q;
                            buf_full_d = 1'b0;
                        end else if (in_xfer) begin
                            // Block arriving on the last-row edge goes straight to the shifter
                            shreg_d = A;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        shreg_d = {shreg_q[BLK_W-ROW_W-1:0], {ROW_W{1'b0}}};
                    end
                end
`ifdef WHIRLPOOL_MU_PREFETCH_EN
                if (in_xfer && !last_xfer) begin
                    buf_d      = A;
                    buf_full_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            row_q   <= row_d;
        end
    end

`ifdef WHIRLPOOL_MU_PREFETCH_EN
    // Prefetch holding buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

endmodule
